// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the BMU power sequencer.
// State encoding is also exported on seq_state for debug LEDs.
package pwr_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_W_VC   = 4'd1,
        ST_D_VC   = 4'd2,
        ST_W_18   = 4'd3,
        ST_D_18   = 4'd4,
        ST_W_33   = 4'd5,
        ST_D_33   = 4'd6,
        ST_W_11   = 4'd7,
        ST_D_11   = 4'd8,
        ST_ON     = 4'd9,
        ST_PD_RST = 4'd10,
        ST_PD_11  = 4'd11,
        ST_PD_33  = 4'd12,
        ST_FAULT  = 4'd13
    } state_t;

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_VCORE = 3'd1;
    localparam logic [2:0] FC_P1V8  = 3'd2;
    localparam logic [2:0] FC_P3V3  = 3'd3;
    localparam logic [2:0] FC_P1V1  = 3'd4;

    localparam int DEF_DLY_UP_MS  = 6;
    localparam int DEF_DLY_RST_MS = 10;
    localparam int DEF_PG_TMO_MS  = 50;
    localparam int DEF_DLY_DN_MS  = 2;
    localparam int DEF_CNT_W      = 8;

    typedef struct packed {
        logic p1v8_en;
        logic p3v3_en;
        logic p1v1_en;
        logic rst_n;
    } outs_t;

    function automatic outs_t state_outs(input state_t s);
        outs_t o;
        o = '0;
        unique case (s)
            ST_W_18, ST_D_18, ST_PD_33:
                o = 4'b1000;
            ST_W_33, ST_D_33, ST_PD_11:
                o = 4'b1100;
            ST_W_11, ST_D_11, ST_PD_RST:
                o = 4'b1110;
            ST_ON:
                o = 4'b1111;
            default:
                o = '0;
        endcase
        return o;
    endfunction

    // Bit 0 = VCORE ... bit 3 = P1V1; lowest lost rail wins.
    function automatic logic [2:0] lost_code(
        input logic [3:0] lost
    );
        if (lost[0])      return FC_VCORE;
        else if (lost[1]) return FC_P1V8;
        else if (lost[2]) return FC_P3V3;
        else if (lost[3]) return FC_P1V1;
        else              return FC_NONE;
    endfunction

endpackage

// File: rtl/pwr_seq_sync.sv
// Parameterised-width two-flop synchroniser, clears to 0.
module pwr_seq_sync #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/pwr_seq_fsm.sv
// Single-FSM power sequencer: ordered rail enables, reset release,
// PWRGD timeout / brown-out fault latching and ordered power-down.
module pwr_seq_fsm
    import pwr_seq_pkg::*;
#(
    parameter int DLY_UP_MS  = DEF_DLY_UP_MS,
    parameter int DLY_RST_MS = DEF_DLY_RST_MS,
    parameter int PG_TMO_MS  = DEF_PG_TMO_MS,
    parameter int DLY_DN_MS  = DEF_DLY_DN_MS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       ms_pulse,
    input  logic       pwr_req,
    input  logic       vcore_pwrgd,
    input  logic       p1v8_pwrgd,
    input  logic       p3v3_pwrgd,
    input  logic       p1v1_pwrgd,
    output logic       p1v8_en,
    output logic       p3v3_en,
    output logic       p1v1_en,
    output logic       pcie_rst_n,
    output logic       phy_rst_n,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       fault_tmo,
    output logic [3:0] seq_state
);

    state_t           r_state;
    state_t           w_nxt;
    state_t           w_adv;
    state_t           w_pd;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]       w_sync;
    logic             w_req;
    logic [3:0]       w_pg;
    logic [3:0]       w_pwr;
    logic [3:0]       w_lost;
    logic             w_wait;
    logic             w_wpg;
    logic             w_in_pd;
    logic [2:0]       w_wcode;
    logic [2:0]       w_fc;
    logic             w_ftmo;
    logic [2:0]       r_fc;
    logic             r_ftmo;
    logic             w_dly_up;
    logic             w_dly_rst;
    logic             w_dly_dn;
    logic             w_tmo_hit;
    outs_t            w_so;
    logic             r_p1v8_en;
    logic             r_p3v3_en;
    logic             r_p1v1_en;
    logic             r_rst_n;
    logic             r_fault;
    logic [2:0]       r_fcode_o;
    logic             r_ftmo_o;

    pwr_seq_sync #(.W(5)) u_sync (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_d     ({pwr_req, p1v1_pwrgd, p3v3_pwrgd,
                   p1v8_pwrgd, vcore_pwrgd}),
        .o_q     (w_sync)
    );

    assign w_req = w_sync[4];
    assign w_pg  = w_sync[3:0];

    assign w_dly_up  = (r_cnt == CNT_W'(DLY_UP_MS));
    assign w_dly_rst = (r_cnt == CNT_W'(DLY_RST_MS));
    assign w_dly_dn  = (r_cnt == CNT_W'(DLY_DN_MS));
    assign w_tmo_hit = (r_cnt == CNT_W'(PG_TMO_MS));

    // Per-state context: powered rails, awaited PG, advance and
    // power-down entry targets (power-down skips steps already off).
    always_comb begin
        w_pwr   = 4'b0000;
        w_wait  = 1'b0;
        w_wpg   = 1'b0;
        w_wcode = FC_NONE;
        w_in_pd = 1'b0;
        w_adv   = r_state;
        w_pd    = ST_IDLE;
        unique case (r_state)
            ST_W_VC: begin
                w_wait  = 1'b1;
                w_wpg   = w_pg[0];
                w_wcode = FC_VCORE;
                if (w_pg[0]) w_adv = ST_D_VC;
            end
            ST_D_VC: begin
                w_pwr = 4'b0001;
                if (w_dly_up) w_adv = ST_W_18;
            end
            ST_W_18: begin
                w_wait  = 1'b1;
                w_wpg   = w_pg[1];
                w_wcode = FC_P1V8;
                if (w_pg[1]) w_adv = ST_D_18;
            end
            ST_D_18: begin
                w_pwr = 4'b0011;
                if (w_dly_up) w_adv = ST_W_33;
            end
            ST_W_33: begin
                w_wait  = 1'b1;
                w_wpg   = w_pg[2];
                w_wcode = FC_P3V3;
                w_pd    = ST_PD_33;
                if (w_pg[2]) w_adv = ST_D_33;
            end
            ST_D_33: begin
                w_pwr = 4'b0111;
                w_pd  = ST_PD_33;
                if (w_dly_up) w_adv = ST_W_11;
            end
            ST_W_11: begin
                w_wait  = 1'b1;
                w_wpg   = w_pg[3];
                w_wcode = FC_P1V1;
                w_pd    = ST_PD_11;
                if (w_pg[3]) w_adv = ST_D_11;
            end
            ST_D_11: begin
                w_pwr = 4'b1111;
                w_pd  = ST_PD_11;
                if (w_dly_rst) w_adv = ST_ON;
            end
            ST_ON: begin
                w_pwr = 4'b1111;
                w_pd  = ST_PD_RST;
            end
            ST_PD_RST: begin
                w_in_pd = 1'b1;
                if (w_dly_dn) w_adv = ST_PD_11;
            end
            ST_PD_11: begin
                w_in_pd = 1'b1;
                if (w_dly_dn) w_adv = ST_PD_33;
            end
            ST_PD_33: begin
                w_in_pd = 1'b1;
                if (w_dly_dn) w_adv = ST_IDLE;
            end
            default: begin
                w_adv = r_state;
            end
        endcase
    end

    // Priority: fault, then req=0, then delay expiry / PG advance.
    always_comb begin
        w_nxt  = r_state;
        w_fc   = FC_NONE;
        w_ftmo = 1'b0;
        w_lost = w_pwr & ~w_pg;
        if (r_state == ST_IDLE) begin
            if (w_req) w_nxt = ST_W_VC;
        end else if (r_state == ST_FAULT) begin
            if (!w_req) w_nxt = ST_IDLE;
        end else if (w_lost != 4'b0000) begin
            w_nxt = ST_FAULT;
            w_fc  = lost_code(w_lost);
        end else if (w_wait && !w_wpg && w_tmo_hit) begin
            w_nxt  = ST_FAULT;
            w_fc   = w_wcode;
            w_ftmo = 1'b1;
        end else if (!w_req && !w_in_pd) begin
            w_nxt = w_pd;
        end else begin
            w_nxt = w_adv;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_fc    <= FC_NONE;
            r_ftmo  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state)
                r_cnt <= '0;
            else if (ms_pulse && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_W'(1);
            if (w_nxt == ST_FAULT && r_state != ST_FAULT) begin
                r_fc   <= w_fc;
                r_ftmo <= w_ftmo;
            end else if (w_nxt != ST_FAULT) begin
                r_fc   <= FC_NONE;
                r_ftmo <= 1'b0;
            end
        end
    end

    assign w_so = state_outs(r_state);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_p1v8_en <= 1'b0;
            r_p3v3_en <= 1'b0;
            r_p1v1_en <= 1'b0;
            r_rst_n   <= 1'b0;
            r_fault   <= 1'b0;
            r_fcode_o <= FC_NONE;
            r_ftmo_o  <= 1'b0;
        end else begin
            r_p1v8_en <= w_so.p1v8_en;
            r_p3v3_en <= w_so.p3v3_en;
            r_p1v1_en <= w_so.p1v1_en;
            r_rst_n   <= w_so.rst_n;
            r_fault   <= (r_state == ST_FAULT);
            r_fcode_o <= r_fc;
            r_ftmo_o  <= r_ftmo;
        end
    end

    assign p1v8_en    = r_p1v8_en;
    assign p3v3_en    = r_p3v3_en;
    assign p1v1_en    = r_p1v1_en;
    assign pcie_rst_n = r_rst_n;
    assign phy_rst_n  = r_rst_n;
    assign fault      = r_fault;
    assign fault_code = r_fcode_o;
    assign fault_tmo  = r_ftmo_o;
    assign seq_state  = r_state;

endmodule

// File: tb/tb_pwr_seq_fsm.sv
// Directed bench for pwr_seq_fsm: power-up timing, faults,
// ordered power-down, abort and asynchronous reset.
module tb_pwr_seq_fsm;
    import pwr_seq_pkg::*;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       ms_pulse;
    logic       pwr_req;
    logic       vcore_pwrgd;
    logic       p1v8_pwrgd;
    logic       p3v3_pwrgd;
    logic       p1v1_pwrgd;
    logic       p1v8_en;
    logic       p3v3_en;
    logic       p1v1_en;
    logic       pcie_rst_n;
    logic       phy_rst_n;
    logic       fault;
    logic [2:0] fault_code;
    logic       fault_tmo;
    logic [3:0] seq_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [13:0] val;
    } exp_t;
    exp_t sb[$];

    pwr_seq_fsm dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .ms_pulse    (ms_pulse),
        .pwr_req     (pwr_req),
        .vcore_pwrgd (vcore_pwrgd),
        .p1v8_pwrgd  (p1v8_pwrgd),
        .p3v3_pwrgd  (p3v3_pwrgd),
        .p1v1_pwrgd  (p1v1_pwrgd),
        .p1v8_en     (p1v8_en),
        .p3v3_en     (p3v3_en),
        .p1v1_en     (p1v1_en),
        .pcie_rst_n  (pcie_rst_n),
        .phy_rst_n   (phy_rst_n),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_tmo   (fault_tmo),
        .seq_state   (seq_state)
    );

    always #10 sys_clk = ~sys_clk;

    // 1 ms tick modelled as one pulse every 10 clocks.
    initial begin
        ms_pulse = 1'b0;
        forever begin
            repeat (9) @(negedge sys_clk);
            ms_pulse = 1'b1;
            @(negedge sys_clk);
            ms_pulse = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [13:0] mk(
        input state_t     s,
        input logic       tmo,
        input logic [2:0] code,
        input logic       flt,
        input logic       rst,
        input logic [2:0] en
    );
        logic [3:0] sv;
        sv = s;
        return {sv, tmo, code, flt, rst, rst, en};
    endfunction

    function automatic logic [13:0] bundle();
        return {seq_state, fault_tmo, fault_code, fault,
                phy_rst_n, pcie_rst_n,
                p1v1_en, p3v3_en, p1v8_en};
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return p1v8_en;
            1:       return p3v3_en;
            2:       return p1v1_en;
            3:       return pcie_rst_n;
            4:       return fault;
            5:       return seq_state == ST_D_18;
            6:       return !pcie_rst_n;
            7:       return !p1v1_en;
            8:       return !p3v3_en;
            9:       return !p1v8_en;
            10:      return seq_state != ST_D_18;
            default: return 1'b0;
        endcase
    endfunction

    task automatic expect_b(input string tag, input logic [13:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check_b();
        exp_t        e;
        logic [13:0] o;
        o = bundle();
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard: empty, observed %h", o);
            return;
        end
        e = sb.pop_front();
        assert (o === e.val) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h",
                   e.tag, o, e.val);
        end
    endtask

    task automatic chk_rng(input string tag, input int dt,
                           input int lo, input int hi);
        checks++;
        assert ((dt >= lo && dt <= hi) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d cycles expected %0d..%0d",
                   tag, dt, lo, hi);
        end
    endtask

    task automatic wait_sig(input int sel, input int budget,
                            output int dt);
        dt = 0;
        while (sig(sel) !== 1'b1) begin
            @(negedge sys_clk);
            dt++;
            if (dt > budget) begin
                checks++;
                errors++;
                $error("FAIL wait_%0d: observed timeout expected event within %0d cycles",
                       sel, budget);
                dt = -1;
                return;
            end
        end
    endtask

    task automatic set_pg(input int i, input logic v);
        case (i)
            0: vcore_pwrgd = v;
            1: p1v8_pwrgd  = v;
            2: p3v3_pwrgd  = v;
            3: p1v1_pwrgd  = v;
            default: ;
        endcase
    endtask

    task automatic clear_all();
        pwr_req = 1'b0;
        for (int i = 0; i < 4; i++) set_pg(i, 1'b0);
        repeat (8) @(negedge sys_clk);
    endtask

    // Raise n PGs, each 1 ms after its enable; dt counts from PG.
    task automatic bring_up(input int n, input bit last);
        int dt;
        pwr_req = 1'b1;
        repeat (10) @(negedge sys_clk);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                wait_sig(i - 1, 200, dt);
                chk_rng($sformatf("en%0d_dly", i - 1), dt, 50, 70);
                repeat (10) @(negedge sys_clk);
            end
            set_pg(i, 1'b1);
        end
        if (last) begin
            wait_sig(n - 1, 200, dt);
            if (n == 4) chk_rng("rst_dly", dt, 90, 110);
            else chk_rng($sformatf("en%0d_dly", n - 1), dt, 50, 70);
        end
    endtask

    logic [13:0] zero_b;
    logic [13:0] on_b;
    int          dt;

    initial begin
        zero_b = mk(ST_IDLE, 1'b0, FC_NONE, 1'b0, 1'b0, 3'b000);
        on_b   = mk(ST_ON, 1'b0, FC_NONE, 1'b0, 1'b1, 3'b111);
        sys_rst_n = 1'b0;
        pwr_req   = 1'b0;
        for (int i = 0; i < 4; i++) set_pg(i, 1'b0);
        repeat (2) @(negedge sys_clk);
        expect_b("reset", zero_b);
        check_b();
        sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        expect_b("idle_after_reset", zero_b);
        check_b();

        bring_up(4, 1'b1);
        expect_b("nominal_on", on_b);
        check_b();

        p1v8_pwrgd = 1'b0;
        repeat (3) @(negedge sys_clk);
        p1v8_pwrgd = 1'b1;
        @(negedge sys_clk);
        expect_b("brownout",
                 mk(ST_FAULT, 1'b0, FC_P1V8, 1'b1, 1'b0, 3'b000));
        check_b();
        clear_all();
        expect_b("brownout_clear", zero_b);
        check_b();

        bring_up(2, 1'b1);
        wait_sig(4, 700, dt);
        chk_rng("pg_timeout", dt, 480, 510);
        expect_b("timeout",
                 mk(ST_FAULT, 1'b1, FC_P3V3, 1'b1, 1'b0, 3'b000));
        check_b();
        clear_all();
        expect_b("timeout_clear", zero_b);
        check_b();

        bring_up(4, 1'b1);
        pwr_req = 1'b0;
        wait_sig(6, 20, dt);
        chk_rng("pd_rst", dt, 2, 6);
        wait_sig(7, 60, dt);
        chk_rng("pd_p1v1", dt, 8, 22);
        wait_sig(8, 60, dt);
        chk_rng("pd_p3v3", dt, 8, 22);
        wait_sig(9, 60, dt);
        chk_rng("pd_p1v8", dt, 8, 22);
        @(negedge sys_clk);
        expect_b("pd_idle", zero_b);
        check_b();
        clear_all();

        bring_up(2, 1'b0);
        wait_sig(5, 20, dt);
        pwr_req = 1'b0;
        wait_sig(10, 20, dt);
        expect_b("abort_state",
                 mk(ST_IDLE, 1'b0, FC_NONE, 1'b0, 1'b0, 3'b001));
        check_b();
        @(negedge sys_clk);
        expect_b("abort_off", zero_b);
        check_b();
        clear_all();

        bring_up(4, 1'b1);
        #3;
        sys_rst_n = 1'b0;
        #1;
        expect_b("async_reset", zero_b);
        check_b();
        clear_all();
        sys_rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        expect_b("reset_release", zero_b);
        check_b();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
